// File: rtl/iir_mac_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : iir_mac_scheduler                                          |
// | Description : Second-order direct-form I IIR filter that time-multiplexes |
// |               one external sign-magnitude multiplier. Each accepted      |
// |               sample takes five multiply-accumulate cycles (b0..b2 on    |
// |               the input history, a1..a2 on the output history), then the |
// |               32-bit result is held until the consumer takes it.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst                 clock, synchronous active-high reset          |
// |   in_valid/in_ready        input sample handshake                        |
// |   in_mag, in_sign          input sample, sign-magnitude (1 = negative)   |
// |   cfg_we/addr/mag/sign     coefficient write (0..2 = b0..b2, 3..4 = a1..a2)|
// |   cfg_err                  one-cycle pulse when a write is dropped       |
// |   mul_a_*, mul_b_*         operands to the shared multiplier             |
// |   mul_out/sign/ovf         same-cycle product magnitude, sign, overflow  |
// |   y_valid/y_ready          result handshake                              |
// |   y_acc                    two's-complement accumulator result           |
// |   y_mag, y_sign            result rescaled by SHIFT, sign-magnitude      |
// |   ovf                      sticky overflow flag                          |
// +--------------------------------------------------------------------------+
module iir_mac_scheduler #(
    parameter int SHIFT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_mag,
    input  logic        in_sign,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [6:0]  cfg_mag,
    input  logic        cfg_sign,
    output logic        cfg_err,
    output logic [6:0]  mul_a_mag,
    output logic        mul_a_sign,
    output logic [6:0]  mul_b_mag,
    output logic        mul_b_sign,
    input  logic [31:0] mul_out,
    input  logic        mul_sign,
    input  logic        mul_ovf,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [31:0] y_acc,
    output logic [6:0]  y_mag,
    output logic        y_sign,
    output logic        ovf
);

    localparam int c_NUM_COEF = 5;
    localparam logic signed [33:0] c_ACC_MAX = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] c_ACC_MIN = 34'sh3_8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL0 = 3'd1,
        S_MUL1 = 3'd2,
        S_MUL2 = 3'd3,
        S_MUL3 = 3'd4,
        S_MUL4 = 3'd5,
        S_DONE = 3'd6
    } state_t;

    // All sign-magnitude values are packed as {sign, mag[6:0]}.
    state_t             r_state;
    logic [7:0]         r_coef [c_NUM_COEF];
    logic [7:0]         r_xCur;
    logic [7:0]         r_xHist1;
    logic [7:0]         r_xHist2;
    logic [7:0]         r_yHist1;
    logic [7:0]         r_yHist2;
    logic signed [31:0] r_acc;
    logic               r_ovf;
    logic               r_cfgErr;
    logic               r_yValid;
    logic [31:0]        r_yAcc;
    logic [6:0]         r_yMag;
    logic               r_ySign;
    logic [7:0]         r_mulA;
    logic [7:0]         r_mulB;

    logic               w_inMul;
    logic [7:0]         w_cfgWord;
    logic [7:0]         w_b0Eff;
    logic signed [33:0] w_addend;
    logic signed [33:0] w_sum;
    logic               w_satHi;
    logic               w_satLo;
    logic [31:0]        w_accNext;
    logic [31:0]        w_absAcc;
    logic [31:0]        w_shifted;
    logic [6:0]         w_resMag;
    logic               w_resSign;

    assign w_inMul   = (r_state == S_MUL0) || (r_state == S_MUL1) || (r_state == S_MUL2) ||
                       (r_state == S_MUL3) || (r_state == S_MUL4);
    assign w_cfgWord = {cfg_sign, cfg_mag};

    // A b0 write landing in the same cycle as an accepted sample must already
    // apply to that sample, so the MUL0 operand bypasses the coefficient store.
    assign w_b0Eff = (cfg_we && (cfg_addr == 3'd0)) ? w_cfgWord : r_coef[0];

    // Signed add of the returned product with saturation to the 32-bit range.
    assign w_addend  = mul_sign ? -$signed({2'b00, mul_out}) : $signed({2'b00, mul_out});
    assign w_sum     = $signed({{2{r_acc[31]}}, r_acc}) + w_addend;
    assign w_satHi   = (w_sum > c_ACC_MAX);
    assign w_satLo   = (w_sum < c_ACC_MIN);
    assign w_accNext = w_satHi ? 32'h7FFF_FFFF :
                       w_satLo ? 32'h8000_0000 : w_sum[31:0];

    // Rescale the final sum; -2^31 has magnitude 2^31, which still fits unsigned.
    assign w_absAcc  = w_accNext[31] ? (~w_accNext + 32'd1) : w_accNext;
    assign w_shifted = w_absAcc >> SHIFT;
    assign w_resMag  = (w_shifted > 32'd127) ? 7'd127 : w_shifted[6:0];
    assign w_resSign = w_accNext[31] && (w_resMag != 7'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < c_NUM_COEF; i++) begin
                r_coef[i] <= 8'd0;
            end
            r_xCur   <= 8'd0;
            r_xHist1 <= 8'd0;
            r_xHist2 <= 8'd0;
            r_yHist1 <= 8'd0;
            r_yHist2 <= 8'd0;
            r_acc    <= 32'sd0;
            r_ovf    <= 1'b0;
            r_cfgErr <= 1'b0;
            r_yValid <= 1'b0;
            r_yAcc   <= 32'd0;
            r_yMag   <= 7'd0;
            r_ySign  <= 1'b0;
            r_mulA   <= 8'd0;
            r_mulB   <= 8'd0;
        end else begin
            // Coefficients only change between samples; anything else is dropped.
            r_cfgErr <= 1'b0;
            if (cfg_we) begin
                if (r_state == S_IDLE) begin
                    case (cfg_addr)
                        3'd0:    r_coef[0] <= w_cfgWord;
                        3'd1:    r_coef[1] <= w_cfgWord;
                        3'd2:    r_coef[2] <= w_cfgWord;
                        3'd3:    r_coef[3] <= w_cfgWord;
                        3'd4:    r_coef[4] <= w_cfgWord;
                        default: ;
                    endcase
                end else begin
                    r_cfgErr <= 1'b1;
                end
            end

            if (w_inMul) begin
                r_acc <= w_accNext;
                if (mul_ovf || w_satHi || w_satLo) begin
                    r_ovf <= 1'b1;
                end
            end

            // Operand registers are loaded one cycle ahead so the multiplier
            // sees step k's operands for the whole of the MULk cycle.
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_xCur  <= {in_sign, in_mag};
                        r_acc   <= 32'sd0;
                        r_mulA  <= w_b0Eff;
                        r_mulB  <= {in_sign, in_mag};
                        r_state <= S_MUL0;
                    end
                end
                S_MUL0: begin
                    r_mulA  <= r_coef[1];
                    r_mulB  <= r_xHist1;
                    r_state <= S_MUL1;
                end
                S_MUL1: begin
                    r_mulA  <= r_coef[2];
                    r_mulB  <= r_xHist2;
                    r_state <= S_MUL2;
                end
                S_MUL2: begin
                    r_mulA  <= r_coef[3];
                    r_mulB  <= r_yHist1;
                    r_state <= S_MUL3;
                end
                S_MUL3: begin
                    r_mulA  <= r_coef[4];
                    r_mulB  <= r_yHist2;
                    r_state <= S_MUL4;
                end
                S_MUL4: begin
                    r_mulA   <= 8'd0;
                    r_mulB   <= 8'd0;
                    r_yAcc   <= w_accNext;
                    r_yMag   <= w_resMag;
                    r_ySign  <= w_resSign;
                    r_yValid <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    // Histories advance only once the consumer has the result,
                    // so a stalled output never corrupts the filter state.
                    if (y_ready) begin
                        r_xHist2 <= r_xHist1;
                        r_xHist1 <= r_xCur;
                        r_yHist2 <= r_yHist1;
                        r_yHist1 <= {r_ySign, r_yMag};
                        r_yValid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Not ready while reset is asserted, even if the state already reads IDLE.
    assign in_ready   = (r_state == S_IDLE) && !rst;
    assign cfg_err    = r_cfgErr;
    assign mul_a_mag  = r_mulA[6:0];
    assign mul_a_sign = r_mulA[7];
    assign mul_b_mag  = r_mulB[6:0];
    assign mul_b_sign = r_mulB[7];
    assign y_valid    = r_yValid;
    assign y_acc      = r_yAcc;
    assign y_mag      = r_yMag;
    assign y_sign     = r_ySign;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_iir_mac_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_iir_mac_scheduler                                       |
// | Description : Self-checking bench for iir_mac_scheduler. Provides the     |
// |               external multiplier, applies a table of hand-computed      |
// |               samples and several multi-cycle corner-case sequences.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_iir_mac_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_mag = 7'd0;
    logic        in_sign = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [6:0]  cfg_mag = 7'd0;
    logic        cfg_sign = 1'b0;
    logic        cfg_err;
    logic [6:0]  mul_a_mag;
    logic        mul_a_sign;
    logic [6:0]  mul_b_mag;
    logic        mul_b_sign;
    logic [31:0] mul_out;
    logic        mul_sign;
    logic        mul_ovf = 1'b0;
    logic        y_valid;
    logic        y_ready = 1'b0;
    logic [31:0] y_acc;
    logic [6:0]  y_mag;
    logic        y_sign;
    logic        ovf;

    // Big-product mode replaces the multiplier with a huge constant to drive
    // the accumulator into saturation.
    logic        bigMode = 1'b0;
    logic        bigSign = 1'b0;

    int total = 0;
    int bad   = 0;
    int cycleCnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    assign mul_out  = bigMode ? 32'h4000_0000 : (32'(mul_a_mag) * 32'(mul_b_mag));
    assign mul_sign = bigMode ? bigSign : (mul_a_sign ^ mul_b_sign);

    iir_mac_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mag     (in_mag),
        .in_sign    (in_sign),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mag    (cfg_mag),
        .cfg_sign   (cfg_sign),
        .cfg_err    (cfg_err),
        .mul_a_mag  (mul_a_mag),
        .mul_a_sign (mul_a_sign),
        .mul_b_mag  (mul_b_mag),
        .mul_b_sign (mul_b_sign),
        .mul_out    (mul_out),
        .mul_sign   (mul_sign),
        .mul_ovf    (mul_ovf),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_acc      (y_acc),
        .y_mag      (y_mag),
        .y_sign     (y_sign),
        .ovf        (ovf)
    );

    typedef struct {
        bit          doRst;
        logic [7:0]  c0, c1, c2, c3, c4;
        logic        xs;
        logic [6:0]  xm;
        logic [31:0] eAcc;
        logic [6:0]  eMag;
        logic        eSign;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; y_ready = 1'b0; mul_ovf = 1'b0;
        step();
        chk("in_ready during rst", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("in_ready after rst", in_ready, 1'b1);
        chk("reset y_valid", y_valid, 1'b0);
        chk("reset y_acc", y_acc, 32'd0);
        chk("reset y_mag/sign", {y_sign, y_mag}, 8'd0);
        chk("reset ovf", ovf, 1'b0);
        chk("reset cfg_err", cfg_err, 1'b0);
        chk("reset mul ops", {mul_a_sign, mul_a_mag, mul_b_sign, mul_b_mag}, 16'd0);
        step();
    endtask

    task automatic writeCoef(input logic [2:0] addr, input logic [7:0] val);
        cfg_we = 1'b1; cfg_addr = addr; cfg_sign = val[7]; cfg_mag = val[6:0];
        step();
        cfg_we = 1'b0;
    endtask

    task automatic setCoefs(input logic [7:0] c0, c1, c2, c3, c4);
        writeCoef(3'd0, c0); writeCoef(3'd1, c1); writeCoef(3'd2, c2);
        writeCoef(3'd3, c3); writeCoef(3'd4, c4);
    endtask

    // cyc 0 is the accept cycle T, cyc 1..5 are MUL0..MUL4; ends at the DONE cycle.
    task automatic startSample(input logic xs, input logic [6:0] xm, input int cfgAt,
                               input logic [2:0] cAddr, input logic [7:0] cVal, input int ovfAt);
        int w = 0;
        while (!in_ready && w < 20) begin step(); w++; end
        chk("in_ready before sample", in_ready, 1'b1);
        for (int cyc = 0; cyc <= 5; cyc++) begin
            in_valid = (cyc == 0); in_sign = xs; in_mag = xm;
            cfg_we   = (cyc == cfgAt); cfg_addr = cAddr; cfg_sign = cVal[7]; cfg_mag = cVal[6:0];
            mul_ovf  = (cyc == ovfAt);
            if (cfgAt >= 0 && cyc == cfgAt + 1) chk("cfg_err after write", cfg_err, (cfgAt >= 1));
            if (cfgAt >= 1 && cyc == cfgAt + 2) chk("cfg_err one cycle", cfg_err, 1'b0);
            if (cyc == 3) chk("no early y_valid", y_valid, 1'b0);
            step();
        end
        in_valid = 1'b0; cfg_we = 1'b0; mul_ovf = 1'b0;
        chk("y_valid at T+6", y_valid, 1'b1);
        chk("mul ops zero in DONE", {mul_a_mag, mul_b_mag}, 14'd0);
    endtask

    task automatic finishSample(input logic [31:0] eAcc, input logic [6:0] eMag,
                                input logic eSign, input logic eOvf);
        chk("y_acc", y_acc, eAcc);
        chk("y_mag", y_mag, eMag);
        chk("y_sign", y_sign, eSign);
        chk("ovf", ovf, eOvf);
        y_ready = 1'b1;
        step();
        y_ready = 1'b0;
        chk("idle after handshake", in_ready, 1'b1);
        chk("y_valid dropped", y_valid, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            rst   b0     b1     b2     a1     a2    xs    xm      eAcc          eMag   eSign
        vecs[0]  = '{1'b1, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 7'd5,   32'd320,      7'd5,   1'b0};
        vecs[1]  = '{1'b1, 8'h40, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0, 7'd64,  32'd4096,     7'd64,  1'b0};
        vecs[2]  = '{1'b0, 8'h40, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0, 7'd0,   32'd2048,     7'd32,  1'b0};
        vecs[3]  = '{1'b0, 8'h40, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0, 7'd0,   32'd1024,     7'd16,  1'b0};
        vecs[4]  = '{1'b0, 8'h40, 8'h00, 8'h00, 8'h20, 8'h00, 1'b0, 7'd0,   32'd512,      7'd8,   1'b0};
        vecs[5]  = '{1'b1, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 1'b0, 7'd127, 32'd16129,    7'd127, 1'b0};
        vecs[6]  = '{1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 1'b0, 7'd127, 32'd32258,    7'd127, 1'b0};
        vecs[7]  = '{1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 1'b0, 7'd127, 32'd48387,    7'd127, 1'b0};
        vecs[8]  = '{1'b1, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 7'd10,  32'hFFFF_FD80, 7'd10,  1'b1};
        vecs[9]  = '{1'b0, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 7'd3,   32'd192,      7'd3,   1'b0};
        vecs[10] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 7'd5,   32'hFFFF_FFFB, 7'd0,  1'b0};
        vecs[11] = '{1'b1, 8'h40, 8'hA0, 8'h00, 8'h00, 8'h90, 1'b0, 7'd8,   32'd512,      7'd8,   1'b0};
        vecs[12] = '{1'b0, 8'h40, 8'hA0, 8'h00, 8'h00, 8'h90, 1'b0, 7'd4,   32'd0,        7'd0,   1'b0};
        vecs[13] = '{1'b0, 8'h40, 8'hA0, 8'h00, 8'h00, 8'h90, 1'b0, 7'd0,   32'hFFFF_FF00, 7'd4,  1'b1};
        vecs[14] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h90, 8'h00, 1'b0, 7'd0,   32'd64,       7'd1,   1'b0};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].doRst) doReset();
            setCoefs(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].c4);
            startSample(vecs[i].xs, vecs[i].xm, -1, 3'd0, 8'h00, -1);
            finishSample(vecs[i].eAcc, vecs[i].eMag, vecs[i].eSign, 1'b0);
        end

        // Multiplier overflow in MUL2 sets a sticky flag.
        doReset();
        setCoefs(8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
        startSample(1'b0, 7'd2, -1, 3'd0, 8'h00, 3);
        finishSample(32'd128, 7'd2, 1'b0, 1'b1);
        startSample(1'b0, 7'd1, -1, 3'd0, 8'h00, -1);
        finishSample(32'd64, 7'd1, 1'b0, 1'b1);

        // Accumulator saturation in both directions.
        doReset();
        bigMode = 1'b1; bigSign = 1'b0;
        startSample(1'b0, 7'd0, -1, 3'd0, 8'h00, -1);
        finishSample(32'h7FFF_FFFF, 7'd127, 1'b0, 1'b1);
        bigSign = 1'b1;
        startSample(1'b0, 7'd0, -1, 3'd0, 8'h00, -1);
        finishSample(32'h8000_0000, 7'd127, 1'b1, 1'b1);
        bigMode = 1'b0; bigSign = 1'b0;

        // Write during MUL1 is dropped and flagged; b0 stays +64.
        doReset();
        setCoefs(8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
        startSample(1'b0, 7'd5, 2, 3'd0, 8'h0A, -1);
        finishSample(32'd320, 7'd5, 1'b0, 1'b0);
        startSample(1'b0, 7'd3, -1, 3'd0, 8'h00, -1);
        finishSample(32'd192, 7'd3, 1'b0, 1'b0);

        // Write coinciding with accept applies to that sample; addr 5 is ignored.
        doReset();
        startSample(1'b0, 7'd7, 0, 3'd0, 8'h40, -1);
        finishSample(32'd448, 7'd7, 1'b0, 1'b0);
        writeCoef(3'd5, 8'h7F);
        chk("cfg_err on addr 5", cfg_err, 1'b0);
        startSample(1'b0, 7'd0, -1, 3'd0, 8'h00, -1);
        finishSample(32'd0, 7'd0, 1'b0, 1'b0);

        // Reset in MUL3 aborts the sample and clears histories.
        doReset();
        setCoefs(8'h40, 8'h40, 8'h00, 8'h00, 8'h00);
        startSample(1'b0, 7'd10, -1, 3'd0, 8'h00, -1);
        finishSample(32'd640, 7'd10, 1'b0, 1'b0);
        begin
            int seen = 0;
            in_valid = 1'b1; in_sign = 1'b0; in_mag = 7'd3;
            step();
            in_valid = 1'b0;
            step(); step(); step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            #1;
            chk("idle after abort", in_ready, 1'b1);
            for (int k = 0; k < 8; k++) begin
                if (y_valid) seen++;
                step();
            end
            chk("no y_valid after abort", seen, 0);
        end
        setCoefs(8'h40, 8'h40, 8'h00, 8'h40, 8'h00);
        startSample(1'b0, 7'd2, -1, 3'd0, 8'h00, -1);
        finishSample(32'd128, 7'd2, 1'b0, 1'b0);

        // Consumer stall holds the result and keeps the input closed.
        doReset();
        setCoefs(8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
        startSample(1'b0, 7'd9, -1, 3'd0, 8'h00, -1);
        for (int k = 0; k < 10; k++) begin
            chk("stalled outputs", {y_valid, in_ready, y_sign, y_mag, y_acc[15:0]},
                {1'b1, 1'b0, 1'b0, 7'd9, 16'd576});
            step();
        end
        finishSample(32'd576, 7'd9, 1'b0, 1'b0);

        // Back-to-back samples with both handshakes held high.
        doReset();
        setCoefs(8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
        begin
            int t1 = -1;
            int t2 = -1;
            in_valid = 1'b1; in_sign = 1'b0; in_mag = 7'd1; y_ready = 1'b1;
            for (int k = 0; k < 40 && t2 < 0; k++) begin
                if (y_valid) begin
                    if (t1 < 0) t1 = cycleCnt;
                    else t2 = cycleCnt;
                end
                if (t2 < 0) step();
            end
            in_valid = 1'b0;
            step();
            y_ready = 1'b0;
            chk("sample period", t2 - t1, 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iir_mac_scheduler.md
IIR_MAC_SCHEDULER -- requirements
Module: iir_mac_scheduler

Interface
REQ-001 Parameter SHIFT, default 6, SHALL be the fixed-point fraction width of coefficients (coefficient magnitude 64 = 1.0).
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 in_valid  in  1  SHALL mean a new input sample is offered.
REQ-005 in_ready  out  1  SHALL mean the block accepts a sample this cycle.
REQ-006 in_mag  in  7  SHALL carry the input sample magnitude; in_sign  in  1 SHALL carry its sign (1 = negative).
REQ-007 cfg_we  in  1, cfg_addr  in  3, cfg_mag  in  7, cfg_sign  in  1  SHALL form the coefficient write port: addr 0..2 = b0..b2, 3..4 = a1..a2.
REQ-008 cfg_err  out  1  SHALL pulse when a write is dropped.
REQ-009 mul_a_mag  out  7, mul_a_sign  out  1, mul_b_mag  out  7, mul_b_sign  out  1  SHALL drive the shared sign-magnitude multiplier operands.
REQ-010 mul_out  in  32, mul_sign  in  1, mul_ovf  in  1  SHALL return the product magnitude, sign and overflow combinationally, in the same cycle.
REQ-011 y_valid  out  1  SHALL flag a held result; y_ready  in  1 SHALL mean the consumer accepts it.
REQ-012 y_acc  out  32  SHALL carry the signed two's-complement accumulator result.
REQ-013 y_mag  out  7, y_sign  out  1  SHALL carry the rescaled sign-magnitude result.
REQ-014 ovf  out  1  SHALL be a sticky overflow flag.

Function
REQ-015 Filter SHALL be direct-form I: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] + a1·y[n-1] + a2·y[n-2]; the sign of each coefficient is carried in the coefficient itself.
REQ-016 States SHALL be IDLE, MUL0..MUL4 and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Handshake in IDLE: in_valid=1 at cycle T SHALL latch x, clear the accumulator and enter MUL0 at T+1.
REQ-018 Step k SHALL occupy exactly one cycle, in fixed operand order: MUL0 b0·x[n], MUL1 b1·x[n-1], MUL2 b2·x[n-2], MUL3 a1·y[n-1], MUL4 a2·y[n-2].
REQ-019 Each MULk cycle SHALL add ±mul_out to the accumulator, with the sign taken from mul_sign.
REQ-020 The accumulator SHALL saturate to +2^31-1 / -2^31 on signed overflow and set ovf.
REQ-021 mul_ovf=1 in any MULk cycle SHALL set ovf; ovf SHALL clear only on rst.
REQ-022 Outside MULk states all mul_* operand outputs SHALL be 0.
REQ-023 DONE SHALL be entered at T+6 with y_valid=1; y_acc, y_mag and y_sign SHALL stay stable until y_ready=1.
REQ-024 Rescaling: y_mag = min(|y_acc| >>> SHIFT, 127); y_sign = (y_acc < 0) when y_mag ≠ 0, else 0.
REQ-025 Handshake in DONE: the cycle with y_ready=1 SHALL shift x[n-1]→x[n-2], x[n]→x[n-1], y[n-1]→y[n-2], (y_mag, y_sign)→y[n-1], drop y_valid next cycle and return to IDLE.
REQ-026 Minimum sample period SHALL be 7 cycles; y_ready held high SHALL sustain that rate.
REQ-027 cfg_we in IDLE with addr ≤ 4 SHALL update that coefficient at the next edge, taking effect from the next sample.
REQ-028 A cfg_we in IDLE with addr 5..7 SHALL be ignored with cfg_err = 0.
REQ-029 cfg_we outside IDLE SHALL be dropped and cfg_err SHALL pulse for one cycle.
REQ-030 If cfg_we and in_valid coincide in IDLE, both SHALL take effect; the new coefficient SHALL apply to the sample accepted in that same cycle.

Reset
REQ-031 rst=1 SHALL force IDLE and zero all coefficients, histories, accumulator, ovf, y_valid, y_*, cfg_err and mul_* outputs.
REQ-032 in_ready SHALL be 0 during the rst cycle and 1 the cycle after.
REQ-033 rst in any MULk or DONE state SHALL abort the sample; no y_valid SHALL be produced for it.

Verification
REQ-034 b0=+64, other coefficients 0, x=+5 -> y_valid at T+6, y_acc=320, y_mag=5, y_sign=0.
REQ-035 b0=+64, a1=+32, impulse x=+64 followed by zeros -> y_mag sequence 64, 32, 16, 8, all positive.
REQ-036 b0=b1=b2=+127, x=+127 three times -> third y_acc=48387, y_mag saturates to 127, ovf=0.
REQ-037 Bench forces mul_ovf=1 during MUL2 -> ovf=1 and stays 1 through later samples until rst.
REQ-038 cfg_we issued in MUL1 -> cfg_err pulses one cycle and the coefficient is unchanged; rst asserted in MUL3 -> IDLE next cycle, no y_valid, histories zero.
REQ-039 y_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0; y_ready=1 -> IDLE next cycle.
